// File: rtl/id_pkg.sv
// Shared constants for the decode-stage register file and load-use scoreboard.
package id_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int LOAD_LAT_MAX = 7;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: two combinational read ports, one write port,
// hardwired zero register and write-through bypass from the writeback port.
module regfile_2r1w
    import id_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Register 0 wins over the bypass so a write to x0 can never leak through.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_we && wb_addr == rs1_addr) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_we && wb_addr == rs2_addr) begin
            rs2_data = wb_data;
        end
    end

endmodule

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with per-register load countdown scoreboard that
// produces the load-use stall and the issue handshake for IF/ID and ID/EX.
module id_regfile_sb
    import id_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int LOAD_LAT = 1,
    parameter int CW       = $clog2(LOAD_LAT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [AW-1:0]       rs1_addr,
    input  logic [AW-1:0]       rs2_addr,
    input  logic                rs1_used,
    input  logic                rs2_used,
    input  logic [AW-1:0]       rd_addr,
    input  logic                rd_we,
    input  logic                rd_is_load,
    input  logic                flush,
    input  logic                wb_we,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic                stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] busy_mask
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT);

    logic [CW-1:0] cnt [NUM_REGS];
    logic          raw;
    logic          waw;
    logic          load_set;

    regfile_2r1w #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_mask[i] = (cnt[i] != '0);
        end
    end

    assign raw        = (rs1_used && busy_mask[rs1_addr]) || (rs2_used && busy_mask[rs2_addr]);
    assign waw        = rd_we && (rd_addr != '0) && busy_mask[rd_addr];
    assign stall      = issue_valid && !flush && (raw || waw);
    assign issue_fire = issue_valid && !flush && !stall;
    assign load_set   = issue_fire && rd_we && rd_is_load && (rd_addr != '0);

    // Counters ignore flush and wb_*: an issued load always completes its countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (load_set && rd_addr == AW'(i)) begin
                    cnt[i] <= LOAD_VAL;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Scoreboard bench for id_regfile_sb: two instances (LOAD_LAT=1 and 3) share stimulus;
// each vector names the instance whose outputs are compared.
module tb_id_regfile_sb;
    import id_pkg::*;

    localparam int XLEN = XLEN_DEF;
    localparam int NR   = NUM_REGS_DEF;
    localparam int AW   = $clog2(NR);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid = 1'b0;
    logic [AW-1:0]   rs1_addr = '0, rs2_addr = '0, rd_addr = '0, wb_addr = '0;
    logic            rs1_used = 1'b0, rs2_used = 1'b0, rd_we = 1'b0, rd_is_load = 1'b0;
    logic            flush = 1'b0, wb_we = 1'b0;
    logic [XLEN-1:0] wb_data = '0;

    logic [XLEN-1:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic            a_stall, a_fire, b_stall, b_fire;
    logic [NR-1:0]   a_busy, b_busy;

    id_regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .LOAD_LAT(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_addr(rd_addr), .rd_we(rd_we), .rd_is_load(rd_is_load), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs1_data(a_rs1), .rs2_data(a_rs2), .stall(a_stall), .issue_fire(a_fire),
        .busy_mask(a_busy)
    );

    id_regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .LOAD_LAT(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_addr(rd_addr), .rd_we(rd_we), .rd_is_load(rd_is_load), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs1_data(b_rs1), .rs2_data(b_rs2), .stall(b_stall), .issue_fire(b_fire),
        .busy_mask(b_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        bit              sel;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic            st;
        logic            fi;
        logic [NR-1:0]   busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: samples 2 time units after either clock edge, well clear of the rising edge.
    initial begin
        exp_t            e;
        logic [XLEN-1:0] r1, r2;
        logic            st, fi;
        logic [NR-1:0]   bm;
        forever begin
            @(posedge clk or negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                r1 = e.sel ? b_rs1   : a_rs1;
                r2 = e.sel ? b_rs2   : a_rs2;
                st = e.sel ? b_stall : a_stall;
                fi = e.sel ? b_fire  : a_fire;
                bm = e.sel ? b_busy  : a_busy;
                checks++;
                if (r1 !== e.r1 || r2 !== e.r2 || st !== e.st || fi !== e.fi || bm !== e.busy) begin
                    errors++;
                    $display("FAIL %s lat%0d got rs1=%h rs2=%h stall=%b fire=%b busy=%h want rs1=%h rs2=%h stall=%b fire=%b busy=%h",
                             e.name, e.sel ? 3 : 1, r1, r2, st, fi, bm, e.r1, e.r2, e.st, e.fi, e.busy);
                end
            end
        end
    end

    task automatic push(input string nm, input bit sel, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                        input logic es, input logic ef, input logic [NR-1:0] eb);
        exp_t e;
        e.name = nm; e.sel = sel; e.r1 = e1; e.r2 = e2; e.st = es; e.fi = ef; e.busy = eb;
        exp_q.push_back(e);
    endtask

    task automatic step(input string nm, input bit sel, input logic rv, input logic iv,
                        input logic [AW-1:0] a1, input logic u1, input logic [AW-1:0] a2, input logic u2,
                        input logic [AW-1:0] rd, input logic we, input logic ld, input logic fl,
                        input logic wwe, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                        input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                        input logic es, input logic ef, input logic [NR-1:0] eb);
        @(posedge clk);
        #1;
        rst_n = rv; issue_valid = iv;
        rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2;
        rd_addr = rd; rd_we = we; rd_is_load = ld; flush = fl;
        wb_we = wwe; wb_addr = wa; wb_data = wd;
        push(nm, sel, e1, e2, es, ef, eb);
    endtask

    task automatic idle(input string nm, input bit sel, input logic [NR-1:0] eb);
        step(nm, sel, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb);
    endtask

    task automatic load(input string nm, input bit sel, input logic [AW-1:0] rd,
                        input logic es, input logic ef, input logic [NR-1:0] eb);
        step(nm, sel, 1, 1, 0, 0, 0, 0, rd, 1, 1, 0, 0, 0, 0, 0, 0, es, ef, eb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // name                 sel rst iv  rs1 u1 rs2 u2 rd we ld fl wwe wa wd          e_rs1        e_rs2        st fi busy
        step("reset",            0, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0,           0,           0,           0, 1, 0);
        step("read_after_reset", 0, 1, 0,  5, 1,  6, 1, 0, 0, 0, 0, 0,  0, 0,           0,           0,           0, 0, 0);
        step("wb_bypass",        0, 1, 0,  5, 1,  0, 0, 0, 0, 0, 0, 1,  5, 32'hDEADBEEF, 32'hDEADBEEF, 0,          0, 0, 0);
        step("wr_r0_dropped",    0, 1, 0,  0, 1,  5, 1, 0, 0, 0, 0, 1,  0, 32'h1234,    0,           32'hDEADBEEF, 0, 0, 0);
        step("l1_load_issue",    0, 1, 1,  5, 1,  0, 0, 3, 1, 1, 0, 0,  0, 0,           32'hDEADBEEF, 0,          0, 1, 0);
        step("l1_use_stall",     0, 1, 1,  0, 0,  3, 1, 10,1, 0, 0, 0,  0, 0,           0,           0,           1, 0, 32'h8);
        step("l1_use_issue",     0, 1, 1,  0, 0,  3, 1, 10,1, 0, 0, 0,  0, 0,           0,           0,           0, 1, 0);
        load("l1_load_r0",       0, 0, 0, 1, 0);
        step("l1_r0_no_stall",   0, 1, 1,  0, 1,  0, 1, 0, 1, 1, 0, 0,  0, 0,           0,           0,           0, 1, 0);
        step("reset_between",    0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0,           0,           0,           0, 0, 0);

        load("l3_load_r7",       1, 7, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("l3_use_stall", 1, 1, 1,  7, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0,           0,           0,           1, 0, 32'h80);
        step("l3_use_issue",     1, 1, 1,  7, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0,           0,           0,           0, 1, 0);

        load("l3_load_r8",       1, 8, 0, 1, 0);
        step("indep_issue",      1, 1, 1,  1, 1,  0, 0, 2, 1, 0, 0, 0,  0, 0,           0,           0,           0, 1, 32'h100);
        idle("expire_cnt2",      1, 32'h100);
        idle("expire_cnt1",      1, 32'h100);
        idle("expire_silent",    1, 0);

        load("waw_first",        1, 9, 0, 1, 0);
        idle("waw_cnt3",         1, 32'h200);
        load("waw_block_cnt2",   1, 9, 1, 0, 32'h200);
        load("waw_block_cnt1",   1, 9, 1, 0, 32'h200);
        load("waw_issue",        1, 9, 0, 1, 0);
        idle("waw_reloaded",     1, 32'h200);
        step("flush_raw",        1, 1, 1,  9, 1,  0, 0, 0, 0, 0, 1, 0,  0, 0,           0,           0,           0, 0, 32'h200);
        idle("flush_cnt_runs",   1, 32'h200);
        idle("flush_cnt_done",   1, 0);

        load("dual_load_r11",    1, 11, 0, 1, 0);
        load("dual_load_r12",    1, 12, 0, 1, 32'h800);
        step("dual_raw_a",       1, 1, 1, 11, 1, 12, 1, 0, 0, 0, 0, 0,  0, 0,           0,           0,           1, 0, 32'h1800);
        step("dual_raw_b",       1, 1, 1, 11, 1, 12, 1, 0, 0, 0, 0, 0,  0, 0,           0,           0,           1, 0, 32'h1800);
        step("dual_raw_c",       1, 1, 1, 11, 1, 12, 1, 0, 0, 0, 0, 0,  0, 0,           0,           0,           1, 0, 32'h1000);
        step("dual_raw_issue",   1, 1, 1, 11, 1, 12, 1, 0, 0, 0, 0, 0,  0, 0,           0,           0,           0, 1, 0);

        load("async_load_r4",    1, 4, 0, 1, 0);
        idle("async_cnt3",       1, 32'h10);
        idle("async_cnt2",       1, 32'h10);
        // Assert reset mid-cycle; the sample lands before the next rising edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        push("async_reset_clear", 1, 0, 0, 0, 0, 0);
        step("post_reset_user",  1, 1, 1,  4, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0,           0,           0,           0, 1, 0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_regfile_sb.md
# id_regfile_sb

Parametrised decode-stage register file with a load-use scoreboard. It is the next generation of the ID stage's Registers block and its single-cycle `MemRead_ex` stall. It holds NUM_REGS×XLEN architectural registers with two combinational read ports and write-through bypass. Per-register countdown counters track in-flight loads for any load latency, producing `stall` and an issue handshake that the IF/ID and ID/EX pipeline registers consume.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NUM_REGS, 32, register count; register 0 hardwired to zero
- AW, $clog2(NUM_REGS), register address width
- LOAD_LAT, 1, number of stall cycles a dependent instruction needs after a load issues; legal range 1..7
- CW, $clog2(LOAD_LAT+1), scoreboard counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  ID holds an instruction requesting issue
- rs1_addr, rs2_addr  in  AW  source register addresses
- rs1_used, rs2_used  in  1  source is actually read by the instruction
- rd_addr  in  AW  destination address
- rd_we  in  1  instruction writes rd
- rd_is_load  in  1  write value comes from memory
- flush  in  1  squash the current ID instruction (taken branch or jump)
- wb_we  in  1  writeback enable
- wb_addr  in  AW  writeback address
- wb_data  in  XLEN  writeback data
- rs1_data, rs2_data  out  XLEN  source operands, bypassed
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX (IFWrite = ~stall)
- issue_fire  out  1  instruction leaves ID this cycle
- busy_mask  out  NUM_REGS  bit i set when cnt[i] != 0

## Operation
- Read: rsN_data returns 0 if rsN_addr==0. Otherwise it returns wb_data if wb_we && wb_addr==rsN_addr. Otherwise it returns regs[rsN_addr].
- Write: on the clock edge, regs[wb_addr] <= wb_data if wb_we && wb_addr!=0. Writes to register 0 are dropped.
- Scoreboard: one counter cnt[i] of width CW per register; cnt[0] is always 0.
- Hazard conditions:
  - raw = (rs1_used && cnt[rs1_addr]!=0) || (rs2_used && cnt[rs2_addr]!=0)
  - waw = rd_we && rd_addr!=0 && cnt[rd_addr]!=0
- stall = issue_valid && !flush && (raw || waw).
- issue_fire = issue_valid && !flush && !stall.
- Counter update each edge, for each i != 0:
  - If issue_fire && rd_we && rd_is_load && rd_addr==i: cnt[i] <= LOAD_LAT. Set has priority.
  - Else if cnt[i] != 0: cnt[i] <= cnt[i]-1.
- Non-load writes never set a counter. ALU results are covered by EX/MEM forwarding outside this block.
- flush suppresses stall and issue_fire in the same cycle. Counters already running keep decrementing, because flush never cancels a load already issued to EX.
- Counters are independent of wb_*. The memory pipeline guarantees that a load's data reaches the EX forwarding path exactly LOAD_LAT+1 cycles after issue_fire.

## Timing
- Reset (rst_n low, asynchronous): all regs = 0, all cnt = 0.
  - Outputs during reset: stall=0, issue_fire=issue_valid&&!flush, busy_mask=0, rs1_data=rs2_data=0 (unless bypassing wb_data).
- Reset deassertion mid-operation: every in-flight load is forgotten and the next cycle sees no hazards. The pipeline must be flushed by the same reset.
- Read latency is 0 cycles (combinational). Write latency is 1 edge, with same-cycle visibility through the bypass.
- Load-use penalty: a dependent instruction directly behind a load stalls exactly LOAD_LAT cycles.
  - With LOAD_LAT=1 this reproduces the legacy single bubble.
- Load followed by independent instructions: no stall. The counter expires silently.
- Load to register 0: no counter is set and there is never a stall.
- Back-to-back loads to the same rd: the second load is blocked by waw until the first load's counter reaches 0.
- Simultaneous raw on both sources: a single stall. The stall lasts until the larger of the two counters reaches 0.

## Structure
- Shared package `id_pkg`: LOAD_LAT_MAX=7 and the default XLEN/NUM_REGS constants. The bench imports the same constants.
- One natural sub-module, `regfile_2r1w`: storage, zero register and write-through bypass.
- The scoreboard counters, hazard logic and handshake stay in the top module.

## Test plan
- Reset, then a read of any register: rs1_data=0, rs2_data=0, busy_mask=0, stall=0.
- Write/read bypass: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF with rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF immediately. A write to register 0 with 0x1234 -> register 0 still reads 0.
- LOAD_LAT=1: load with rd=3 issues, next instruction uses rs2=3 -> stall=1 for one cycle, then issue_fire=1.
- LOAD_LAT=3: load with rd=7, then a user of register 7 -> stall for exactly 3 cycles; busy_mask[7] follows the counter 3,2,1,0.
- WAW and flush:
  - A load to register 9 while cnt[9]=2 -> stall until cnt[9]=0, then the counter reloads.
  - flush=1 during a raw hazard -> stall=0 and issue_fire=0, while the counters continue decrementing.
- Asynchronous reset asserted while cnt[4]=2 -> busy_mask=0 immediately, with no clock edge required. After release, a user of register 4 issues with no stall.
